// File: rtl/instr_cache_responder.sv
// Read-only direct-mapped instruction cache. A word read hits in the same
// cycle, and a miss fills a whole 16-byte line from physical memory. Saturating
// hit/miss counters are kept for performance debug.
module instr_cache_responder #(
  parameter int S_INDEX   = 3,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_read,
  input  logic [15:0]          mem_address,
  output logic [15:0]          mem_rdata,
  output logic                 mem_resp,
  output logic                 pmem_read,
  output logic [15:0]          pmem_address,
  input  logic [127:0]         pmem_rdata,
  input  logic                 pmem_resp,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  localparam int LINES = 1 << S_INDEX;
  localparam int TAG_W = 12 - S_INDEX;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [LINES-1:0]     r_valid;
  logic [TAG_W-1:0]     r_tag  [LINES];
  logic [127:0]         r_data [LINES];
  logic [11:0]          r_miss_line;
  logic [CNT_WIDTH-1:0] r_hit_count;
  logic [CNT_WIDTH-1:0] r_miss_count;

  logic [2:0]           w_offset;
  logic [S_INDEX-1:0]   w_index;
  logic [TAG_W-1:0]     w_tag;
  logic [S_INDEX-1:0]   w_fill_index;
  logic [TAG_W-1:0]     w_fill_tag;
  logic [127:0]         w_line;
  logic                 w_hit;
  logic                 w_hit_inc;
  logic                 w_miss_inc;
  logic                 w_fill_we;
  logic                 w_unused;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (v == {CNT_WIDTH{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  endfunction

  assign w_offset     = mem_address[3:1];
  assign w_index      = mem_address[3+S_INDEX:4];
  assign w_tag        = mem_address[15:4+S_INDEX];
  assign w_fill_index = r_miss_line[S_INDEX-1:0];
  assign w_fill_tag   = r_miss_line[11:S_INDEX];
  assign w_line       = r_data[w_index];
  assign w_hit        = r_valid[w_index] && (r_tag[w_index] == w_tag);
  // Byte-select bit of the fetch address has no meaning for word reads.
  assign w_unused     = mem_address[0];

  assign hit_count    = r_hit_count;
  assign miss_count   = r_miss_count;

  // Next-state and response decode; hits answer combinationally from IDLE.
  always_comb begin
    w_state_nxt  = r_state;
    mem_resp     = 1'b0;
    mem_rdata    = 16'h0000;
    pmem_read    = 1'b0;
    pmem_address = 16'h0000;
    w_hit_inc    = 1'b0;
    w_miss_inc   = 1'b0;
    w_fill_we    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mem_read && w_hit) begin
          mem_resp  = 1'b1;
          mem_rdata = w_line[{w_offset, 4'b0000} +: 16];
          w_hit_inc = 1'b1;
        end else if (mem_read) begin
          w_miss_inc  = 1'b1;
          w_state_nxt = ST_FILL;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {r_miss_line, 4'b0000};
        if (pmem_resp) begin
          w_fill_we   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_FILL;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register, miss-line latch and saturating counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_miss_line  <= 12'h000;
      r_hit_count  <= {CNT_WIDTH{1'b0}};
      r_miss_count <= {CNT_WIDTH{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      if (w_miss_inc) begin
        r_miss_line  <= mem_address[15:4];
        r_miss_count <= sat_inc(r_miss_count);
      end
      if (w_hit_inc) begin
        r_hit_count <= sat_inc(r_hit_count);
      end
    end
  end

  // Valid bits are the only line state that needs clearing on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= {LINES{1'b0}};
    end else if (w_fill_we) begin
      r_valid[w_fill_index] <= 1'b1;
    end
  end

  // Tag and data arrays: written only when a fill completes.
  always_ff @(posedge clk) begin
    if (w_fill_we) begin
      r_tag[w_fill_index]  <= w_fill_tag;
      r_data[w_fill_index] <= pmem_rdata;
    end
  end

endmodule

// File: tb/tb_instr_cache_responder.sv
// Scoreboard bench for instr_cache_responder: every read pushes its expected
// word, and the word is popped and compared when mem_resp appears.
module tb_instr_cache_responder;

  logic         clk;
  logic         reset;
  logic         mem_read;
  logic [15:0]  mem_address;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic         pmem_read;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;

  int n_checks = 0;
  int n_errors = 0;
  int exp_hits = 0;
  int exp_misses = 0;
  logic [15:0] sb_q[$];

  instr_cache_responder #(.S_INDEX(3), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_address(mem_address),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .pmem_read(pmem_read),
    .pmem_address(pmem_address), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expectation.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Physical memory contents: word at 0x0046 is 0x1234.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5434;
  endfunction

  function automatic logic [127:0] mem_line(input logic [15:0] a);
    logic [127:0] l;
    logic [15:0]  base;
    base = {a[15:4], 4'b0000};
    for (int k = 0; k < 8; k++) begin
      l[16*k +: 16] = mem_word(base + 16'(2*k));
    end
    return l;
  endfunction

  function automatic int sat(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  // One-cycle synchronous reset; clears the counter model too.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
  endtask

  // Issue a read (caller is at a negedge); services fills after fill_delay
  // cycles and returns at a negedge with mem_read still held.
  task automatic fetch(input logic [15:0] addr, input int fill_delay, output int fills);
    bit done;
    logic [15:0] exp;
    done = 1'b0;
    fills = 0;
    sb_q.push_back(mem_word({addr[15:1], 1'b0}));
    mem_read = 1'b1;
    mem_address = addr;
    for (int c = 0; c < 100 && !done; c++) begin
      #1;
      if (mem_resp) begin
        exp = sb_q.pop_front();
        check("rdata", {16'h0, mem_rdata}, {16'h0, exp});
        check("pmem_read_on_hit", {31'h0, pmem_read}, 32'h0);
        exp_hits = sat(exp_hits);
        done = 1'b1;
      end else if (pmem_read) begin
        check("pmem_address", {16'h0, pmem_address}, {16'h0, addr[15:4], 4'b0000});
        if (fills == 0) begin
          exp_misses = sat(exp_misses);
          check("miss_count_on_fill", {16'h0, miss_count}, exp_misses);
        end
        if (fills == fill_delay) begin
          pmem_resp = 1'b1;
          pmem_rdata = mem_line(addr);
        end
        fills++;
      end
      @(negedge clk);
      pmem_resp = 1'b0;
      pmem_rdata = '0;
    end
    if (!done) begin
      check("fetch_timeout", 32'h0, 32'h1);
      void'(sb_q.pop_front());
    end
  endtask

  task automatic check_counters(input string tag);
    #1;
    check({tag, "_hits"}, {16'h0, hit_count}, exp_hits);
    check({tag, "_misses"}, {16'h0, miss_count}, exp_misses);
  endtask

  int fills;
  int k_hits;

  initial begin
    reset = 1'b1;
    mem_read = 1'b0;
    mem_address = 16'h0;
    pmem_rdata = '0;
    pmem_resp = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mem_resp", {31'h0, mem_resp}, 32'h0);
    check("rst_pmem_read", {31'h0, pmem_read}, 32'h0);
    check("rst_mem_rdata", {16'h0, mem_rdata}, 32'h0);
    check("rst_hits", {16'h0, hit_count}, 32'h0);
    check("rst_misses", {16'h0, miss_count}, 32'h0);

    // First miss on 0x0040: mem_resp stays low in the request cycle.
    @(negedge clk);
    mem_read = 1'b1;
    mem_address = 16'h0046;
    #1;
    check("miss_no_resp", {31'h0, mem_resp}, 32'h0);
    fetch(16'h0046, 5, fills);
    check("first_fill_seen", {31'h0, fills > 0}, 32'h1);
    mem_read = 1'b0;
    check_counters("first");

    // Whole line resident: eight back-to-back single-cycle hits.
    for (int i = 0; i < 8; i++) begin
      fetch(16'h0040 + 16'(2*i), 0, fills);
      check("b2b_no_fill", fills, 32'h0);
    end
    mem_read = 1'b0;
    check_counters("b2b");

    // Aliasing: 0x00C0 evicts 0x0040, which then misses again.
    fetch(16'h00C4, 2, fills);
    check("alias_fill", {31'h0, fills > 0}, 32'h1);
    fetch(16'h0040, 1, fills);
    check("evicted_refill", {31'h0, fills > 0}, 32'h1);
    mem_read = 1'b0;
    check_counters("alias");
    check("alias_miss3", {16'h0, miss_count}, 32'h3);

    // Reset mid-FILL; a late pmem_resp must be ignored.
    @(negedge clk);
    mem_read = 1'b1;
    mem_address = 16'h0200;
    repeat (3) @(negedge clk);
    #1;
    check("fill_before_reset", {31'h0, pmem_read}, 32'h1);
    do_reset();
    #1;
    check("pmem_read_after_reset", {31'h0, pmem_read}, 32'h0);
    pmem_resp = 1'b1;
    pmem_rdata = mem_line(16'h0200);
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    check("idle_after_late_resp", {31'h0, pmem_read}, 32'h0);
    check_counters("post_reset");
    fetch(16'h0040, 0, fills);
    check("reset_invalidates", {31'h0, fills > 0}, 32'h1);
    mem_read = 1'b0;

    // Requester drops mem_read during fill: no response, line still installed.
    @(negedge clk);
    mem_read = 1'b1;
    mem_address = 16'h0100;
    @(negedge clk);
    #1;
    check("drop_fill_addr", {16'h0, pmem_address}, 32'h0100);
    exp_misses = sat(exp_misses);
    mem_read = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 2) begin
        pmem_resp = 1'b1;
        pmem_rdata = mem_line(16'h0100);
      end else begin
        pmem_resp = 1'b0;
      end
      #1;
      check("drop_no_resp", {31'h0, mem_resp}, 32'h0);
    end
    pmem_resp = 1'b0;
    @(negedge clk);
    fetch(16'h0108, 0, fills);
    check("drop_installed", fills, 32'h0);
    mem_read = 1'b0;
    check_counters("drop");

    // Saturation: hold a hitting request until hit_count reaches 0xFFFE.
    do_reset();
    fetch(16'h0040, 0, fills);
    k_hits = 16'hFFFE - exp_hits;
    repeat (k_hits) @(negedge clk);
    exp_hits = exp_hits + k_hits;
    mem_read = 1'b0;
    check_counters("pre_sat");
    for (int i = 0; i < 3; i++) begin
      fetch(16'h0042, 0, fills);
    end
    mem_read = 1'b0;
    #1;
    check("hit_saturated", {16'h0, hit_count}, 32'hFFFF);
    check_counters("sat");
    check("sb_empty", sb_q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_cache_responder.md
Name: instr_cache_responder

Overview:
- Read-only, direct-mapped instruction cache that answers the fetch stage's word-read requests (mem_read/mem_address -> mem_rdata/mem_resp).
- Sits between the fetch PC output and the 128-bit physical memory port.
- On a miss, fetches whole 16-byte lines from physical memory.
- Keeps saturating hit and miss counters for performance debug.

Parameters:
- S_INDEX, 3, number of index bits; the cache has 2^S_INDEX lines (default 8).
- CNT_WIDTH, 16, width of the hit and miss counters.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- mem_read  in  1  fetch request; held high with a stable address until mem_resp
- mem_address  in  16  byte address of the instruction word (bit 0 ignored)
- mem_rdata  out  16  instruction word; valid only while mem_resp=1
- mem_resp  out  1  request complete this cycle
- pmem_read  out  1  line-fill request to physical memory
- pmem_address  out  16  line-aligned fill address
- pmem_rdata  in  128  fill data; word k is bits [16k+15:16k]
- pmem_resp  in  1  fill data valid this cycle
- hit_count  out  CNT_WIDTH  saturating count of hits
- miss_count  out  CNT_WIDTH  saturating count of misses

Behaviour:
- Address split:
  - offset = mem_address[3:1] (word select)
  - index = mem_address[3+S_INDEX:4]
  - tag = mem_address[15:4+S_INDEX] (9 bits by default)
- Storage per line: valid bit, tag, 128-bit data. Reset clears every valid bit; tag and data contents are don't-care.
- Reset values:
  - state = IDLE
  - mem_resp = 0, pmem_read = 0, mem_rdata = 0
  - hit_count = 0, miss_count = 0
- IDLE state:
  - Hit: mem_read=1, valid[index]=1 and the stored tag matches. mem_resp=1 combinationally in the same cycle (0-cycle hit latency); mem_rdata = word[offset] of the line; hit_count increments at the clock edge.
  - Miss: mem_read=1 and no hit. mem_resp=0 and next state = FILL. miss_count increments once per miss, at the IDLE->FILL edge.
  - No request (mem_read=0): mem_resp=0; no state or counter change.
- FILL state:
  - pmem_read=1; pmem_address = {tag, index, 4'b0000}, using the latched miss address.
  - mem_resp=0 throughout.
  - When pmem_resp=1: at that clock edge, write pmem_rdata into the line, set the tag and valid=1, and go to IDLE.
  - The held request then hits on the next cycle, so miss latency = fill cycles + 1.
- The miss address is latched on entry to FILL. If the requester drops mem_read during FILL, the fill still completes and the line is installed, but no mem_resp is generated.
- pmem_resp while in IDLE is ignored.
- Reset during FILL:
  - Next cycle: state = IDLE, pmem_read = 0, all lines invalid.
  - A late pmem_resp is ignored.
- Counters saturate at all-ones and do not wrap.
- The requester must not change mem_address while mem_read=1 and mem_resp=0. Behaviour is undefined if it does.
- Aliasing: an address with the same index but a different tag evicts the old line.

Test Plan:
- Reset, then mem_read with address 0x0040 -> mem_resp=0, FILL entered, pmem_read=1, pmem_address=0x0040, miss_count=1. Return pmem_resp with pmem_rdata word3=0x1234 after 5 cycles -> next cycle, address 0x0046 hits with mem_rdata=0x1234, mem_resp=1 in the same cycle, hit_count=1.
- With line 0x0040 resident, read 0x0040, 0x0042 … 0x004E back-to-back -> 8 consecutive single-cycle hits, each returning the matching word; pmem_read never asserted.
- With 0x0040 resident, read 0x00C0 (same index, different tag) -> miss, fill with pmem_address=0x00C0. A subsequent read of 0x0040 misses again; miss_count=3.
- Assert reset mid-FILL, then pulse pmem_resp -> pmem_read=0 the cycle after reset, state stays IDLE, a read of 0x0040 misses again, both counters read 0.
- Drop mem_read during FILL of 0x0100 -> no mem_resp; after pmem_resp, a later read of 0x0100 hits with no new fill.
- Preload hit_count to 0xFFFE via repeated hits, then issue 3 more hits -> hit_count holds at 0xFFFF.
